bus_snoop_responder: RTL

Bus-side responder for the L2 cache's snooping bus interface. It accepts bus operations (READ, WRITE, INVALIDATE, RWIM) that the cache issues on its bus output and queues them in a small FIFO. After a programmable latency it returns, for each operation, the snoop result that the other processors on the bus would report. It sits between the cache's bus output and the system-level bus model, and replaces trace-level printing with a cycle-accurate responder.

---
 rtl/bus_snoop_responder_pkg.sv | 44 ++++
 rtl/bus_snoop_responder_fifo.sv | 46 ++++
 rtl/bus_snoop_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bus_snoop_responder_pkg.sv
// Shared bus-snoop types: operation and snoop-result encodings, request record,
// responder FSM states, and the snoop-result decode used by the cache and the responder.
package bus_snoop_responder_pkg;

    localparam int BUS_ADDR_W = 32;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2,
        OP_INVAL = 3'd3,
        OP_RWIM  = 3'd4
    } bus_op_e;

    typedef enum logic [1:0] {
        SNP_HIT   = 2'b00,
        SNP_HITM  = 2'b01,
        SNP_NOHIT = 2'b10
    } snoop_result_e;

    typedef struct packed {
        bus_op_e                 op;
        logic [BUS_ADDR_W-1:0]   addr;
    } bus_req_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } rsp_state_e;

    // Only reads (plain or with intent to modify) can find the line in another cache.
    function automatic snoop_result_e snoop_decode(input bus_op_e op, input logic [1:0] a);
        snoop_result_e r;
        r = SNP_NOHIT;
        if (op == OP_READ || op == OP_RWIM) begin
            if (a == 2'b00)      r = SNP_HIT;
            else if (a == 2'b01) r = SNP_HITM;
            else                 r = SNP_NOHIT;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_snoop_responder_fifo.sv
// bus_req_fifo: synchronous request FIFO with one extra pointer bit to tell full from empty.
module bus_req_fifo
    import bus_snoop_responder_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = bus_req_t
) (
    input  logic clk,
    input  logic rstb,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    T             r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/bus_snoop_responder.sv
// Snoop responder: queues cache bus operations and answers each after RESP_LAT cycles.
// Statistics counters are built only when BUS_SNOOP_STATS_EN is defined; otherwise tied to zero.
module bus_snoop_responder
    import bus_snoop_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RESP_LAT   = 2,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              bus_valid,
    input  logic [2:0]        bus_op,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              bus_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_op,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [1:0]        rsp_result,
    output logic [15:0]       cnt_read,
    output logic [15:0]       cnt_write,
    output logic [15:0]       cnt_inval,
    output logic [15:0]       cnt_rwim,
    output logic [15:0]       cnt_hitm,
    output logic [15:0]       cnt_drop
);

    typedef struct packed {
        bus_op_e             op;
        logic [ADDR_W-1:0]   addr;
    } req_t;

    localparam logic [3:0] LAT_INIT = (RESP_LAT == 0) ? 4'd0 : 4'(RESP_LAT - 1);

    bus_op_e        w_op;
    logic           w_legal;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    req_t           w_push_req;
    req_t           w_head;

    rsp_state_e     r_state;
    logic [3:0]     r_lat;
    logic           r_rsp_valid;
    bus_op_e        r_rsp_op;
    logic [ADDR_W-1:0] r_rsp_addr;
    snoop_result_e  r_rsp_result;

    assign w_op       = bus_op_e'(bus_op);
    assign w_legal    = (bus_op >= 3'd1) && (bus_op <= 3'd4);
    assign w_push     = bus_valid && !w_full && w_legal;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_push_req = '{op: w_op, addr: bus_addr};

    bus_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .i_push  (w_push),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus_ready  = !w_full;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_op     = r_rsp_op;
    assign rsp_addr   = r_rsp_addr;
    assign rsp_result = r_rsp_result;

    // The popped request is latched into the response registers, which stay stable until handshake.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state      <= S_IDLE;
            r_lat        <= 4'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_op     <= OP_NONE;
            r_rsp_addr   <= '0;
            r_rsp_result <= SNP_NOHIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_rsp_op     <= w_head.op;
                        r_rsp_addr   <= w_head.addr;
                        r_rsp_result <= snoop_decode(w_head.op, w_head.addr[1:0]);
                        if (RESP_LAT == 0) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_lat   <= LAT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_lat == 4'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_SNOOP_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_cnt_read;
    logic [15:0] r_cnt_write;
    logic [15:0] r_cnt_inval;
    logic [15:0] r_cnt_rwim;
    logic [15:0] r_cnt_hitm;
    logic [15:0] r_cnt_drop;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt_read  <= 16'd0;
            r_cnt_write <= 16'd0;
            r_cnt_inval <= 16'd0;
            r_cnt_rwim  <= 16'd0;
            r_cnt_hitm  <= 16'd0;
            r_cnt_drop  <= 16'd0;
        end else begin
            if (w_push && w_op == OP_READ)  r_cnt_read  <= sat_inc(r_cnt_read);
            if (w_push && w_op == OP_WRITE) r_cnt_write <= sat_inc(r_cnt_write);
            if (w_push && w_op == OP_INVAL) r_cnt_inval <= sat_inc(r_cnt_inval);
            if (w_push && w_op == OP_RWIM)  r_cnt_rwim  <= sat_inc(r_cnt_rwim);
            if (bus_valid && !w_legal)      r_cnt_drop  <= sat_inc(r_cnt_drop);
            if (r_state == S_RESP && rsp_ready && r_rsp_result == SNP_HITM)
                r_cnt_hitm <= sat_inc(r_cnt_hitm);
        end
    end

    assign cnt_read  = r_cnt_read;
    assign cnt_write = r_cnt_write;
    assign cnt_inval = r_cnt_inval;
    assign cnt_rwim  = r_cnt_rwim;
    assign cnt_hitm  = r_cnt_hitm;
    assign cnt_drop  = r_cnt_drop;
`else
    assign cnt_read  = 16'h0;
    assign cnt_write = 16'h0;
    assign cnt_inval = 16'h0;
    assign cnt_rwim  = 16'h0;
    assign cnt_hitm  = 16'h0;
    assign cnt_drop  = 16'h0;
`endif

endmodule
